pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the ALU's fixed 32-bit CLA add/sub.
- Splits a WIDTH-bit add/subtract into WIDTH/BLOCK stages. Each stage resolves one BLOCK-bit carry-lookahead slice and registers the carry into the next stage.
- Raises clock rate for wide operands. Result flags are computed once, at the final stage.
- Sits between the operand-issue logic and the writeback path, with a valid/ready handshake on both sides and tag passthrough.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per pipeline stage; STAGES = WIDTH/BLOCK (≥1).
- TAG_W, 5, width of the opaque tag carried alongside each operation (e.g. destination register).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts the operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A − B (B inverted, carry-in forced to 1); 0 = A + B + in_cin
- in_cin  in  1  carry-in for add; ignored when in_sub=1
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (reset=0, async): every stage valid bit and all outputs are 0. Data registers may reset to 0.
- Reset mid-operation: all in-flight operations are discarded. No result is emitted after reset releases.
- Advance condition: advance = !out_valid || out_ready; in_ready = advance.
  - The whole pipeline shifts on advance and holds every register otherwise (global stall, no bubble collapse).
- Transfer: an operation is accepted when in_valid && in_ready, and is delivered when out_valid && out_ready.
- Latency: an operation accepted at edge N appears on out_* after edge N+STAGES−1 (STAGES cycles if never stalled).
- Throughput: one operation per cycle when out_ready is held high.
- Stage k (0-based):
  - adds slice [k*BLOCK +: BLOCK] of A and of B' (B' = ~B when sub), using carry c_k, where c_0 = in_sub ? 1 : in_cin;
  - registers sum slice k and c_{k+1};
  - forwards the unconsumed upper operand slices, already-computed lower sum slices, tag and valid.
- Final stage:
  - out_cout = c_STAGES;
  - out_ovf = c_WIDTH XOR c_{WIDTH−1}, i.e. the carry into and out of the MSB; the MSB slice also exports its internal MSB carry-in;
  - out_zero = ~|out_sum.
  - All flags are registered together with the sum; nothing is combinational from inputs.
- STAGES=1: single registered stage with latency 1.
- Simultaneous accept and deliver under a full pipeline with out_ready=1 is legal and loses nothing.
- Bubbles: invalid slots flow through. Outputs hold their last values while out_valid=0, and consumers ignore them.

Decomposition:
- Shared package holds:
  - operation encoding (ADD=0, SUB=1);
  - default WIDTH/BLOCK/TAG_W constants;
  - function computing STAGES.
- Sub-module addsub_slice: combinational BLOCK-bit carry-lookahead slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the slice MSB).
  - Instantiated once per stage via generate.
- Top module owns only the pipeline registers, skew registers and handshake.

Test Plan (WIDTH=32, BLOCK=8, so latency 4):
- ADD 0x7FFFFFFF + 0x00000001, cin=0 → sum 0x80000000, ovf=1, cout=0, zero=0, after exactly 4 cycles with the tag preserved.
- ADD 0xFFFFFFFF + 0x00000001 → sum 0x00000000, cout=1, ovf=0, zero=1. Carry must ripple across all 4 stages.
- SUB 5 − 7 → 0xFFFFFFFE, cout=0, ovf=0. SUB 7 − 5 → 0x00000002, cout=1. SUB 0x80000000 − 1 → 0x7FFFFFFF, ovf=1.
- Stream 8 back-to-back ops with tags 0..7, dropping out_ready for 3 cycles mid-stream:
  - in_ready falls in the same cycles;
  - all 8 results emerge in order, tags 0..7, with no duplicate or loss;
  - out_* stay stable while stalled.
- ADD with cin=1, 0x000000FF + 0x00000000 → 0x00000100. The same operands with in_sub=1 ignore cin → 0x000000FF.
- Assert reset while 3 operations are in flight: out_valid=0 immediately (async, before the next edge), and no results appear after release. A new operation then completes with latency 4.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation
// encoding, default geometry and the stage-count helper.
package pipelined_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_BLOCK = 8;
  localparam int unsigned DEF_TAG_W = 5;

  // Number of BLOCK-bit slices (one per pipeline stage), never below one.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned block);
    int unsigned n;
    n = (block == 0) ? 1 : width / block;
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational BLOCK-bit carry-lookahead adder slice; also exports the
// carry into its MSB so the top slice can form signed overflow.
module addsub_slice #(
  parameter int unsigned BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;
  logic             w_run;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat OR of generate terms gated by the propagate run
  // above them, rather than a ripple through the previous carry.
  always_comb begin
    w_c    = '0;
    w_run  = 1'b1;
    w_c[0] = cin;
    for (int i = 0; i < int'(BLOCK); i++) begin
      w_run = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_run & w_g[j]);
        w_run    = w_run & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (w_run & cin);
    end
  end

  assign sum   = w_p ^ w_c[BLOCK-1:0];
  assign cout  = w_c[BLOCK];
  assign c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one BLOCK-bit lookahead slice per stage,
// carry registered between stages, flags formed at the last stage.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned STAGES = calc_stages(WIDTH, BLOCK);

  logic w_adv;

  // Global stall: the whole pipe moves only when the output slot can drain.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO = k * BLOCK;
    localparam int unsigned BW = WIDTH - LO;

    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_acc_nx;
    logic [BW-1:0]    w_b;
    logic             w_c;
    logic             w_v;
    logic [TAG_W-1:0] w_tag;
    logic [BLOCK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;

    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic             r_v;
    logic [TAG_W-1:0] r_tag;

    // r_acc holds finished sum slices below the current one and raw A above.
    if (k == 0) begin : g_head
      assign w_acc = in_a;
      assign w_b   = (op_e'(in_sub) == OP_SUB) ? ~in_b : in_b;
      assign w_c   = in_sub | in_cin;
      assign w_v   = in_valid;
      assign w_tag = in_tag;
    end else begin : g_body
      assign w_acc = g_stage[k-1].r_acc;
      assign w_b   = g_stage[k-1].g_fwd.r_b;
      assign w_c   = g_stage[k-1].r_c;
      assign w_v   = g_stage[k-1].r_v;
      assign w_tag = g_stage[k-1].r_tag;
    end

    addsub_slice #(
      .BLOCK (BLOCK)
    ) u_slice (
      .a     (w_acc[LO +: BLOCK]),
      .b     (w_b[BLOCK-1:0]),
      .cin   (w_c),
      .sum   (w_sum),
      .cout  (w_cout),
      .c_msb (w_cmsb)
    );

    always_comb begin
      w_acc_nx               = w_acc;
      w_acc_nx[LO +: BLOCK]  = w_sum;
    end

    // Data only loads under a valid slot so the outputs hold across bubbles.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_v   <= 1'b0;
        r_acc <= '0;
        r_c   <= 1'b0;
        r_tag <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        if (w_v) begin
          r_acc <= w_acc_nx;
          r_c   <= w_cout;
          r_tag <= w_tag;
        end
      end
    end

    if (BW > BLOCK) begin : g_fwd
      logic [BW-BLOCK-1:0] r_b;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_b <= '0;
        end else if (w_adv && w_v) begin
          r_b <= w_b[BW-1:BLOCK];
        end
      end
    end else begin : g_last
      logic r_ovf;
      logic r_zero;

      // Overflow is the carry into the MSB differing from the carry out.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv && w_v) begin
          r_ovf  <= w_cout ^ w_cmsb;
          r_zero <= ~|w_acc_nx;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign out_sum   = g_stage[STAGES-1].r_acc;
  assign out_cout  = g_stage[STAGES-1].r_c;
  assign out_tag   = g_stage[STAGES-1].r_tag;
  assign out_ovf   = g_stage[STAGES-1].g_last.r_ovf;
  assign out_zero  = g_stage[STAGES-1].g_last.r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (32-bit, 8-bit slices, 4 stages):
// table vectors, a stalled stream and reset with operations in flight.
module tb_pipelined_addsub;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned BLOCK  = 8;
  localparam int unsigned TAG_W  = 5;
  localparam int          STAGES = 4;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  sb_t sbq[$];

  pipelined_addsub #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK),
    .TAG_W (TAG_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic sb_t model(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin,
                                input logic [4:0] tag, input bit lat);
    sb_t         m;
    logic [31:0] bb;
    logic [32:0] s;
    bb     = sub ? ~b : b;
    s      = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
    m.sum  = s[31:0];
    m.cout = s[32];
    m.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
    m.zero = (s[31:0] == 32'h0);
    m.tag  = tag;
    m.acc  = 0;
    m.lat  = lat;
    return m;
  endfunction

  // Output monitor: scoreboard pop, handshake rule and stall stability.
  logic        stalled_prev = 1'b0;
  logic [31:0] p_sum;
  logic [4:0]  p_tag;
  logic        p_cout, p_ovf, p_zero;
  sb_t         e;

  always @(negedge clock) begin
    if (reset) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stalled_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_sum", 64'(out_sum), 64'(p_sum));
        chk("stall_tag", 64'(out_tag), 64'(p_tag));
        chk("stall_flags", 64'({out_cout, out_ovf, out_zero}), 64'({p_cout, p_ovf, p_zero}));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got tag %0d sum %0h want none", out_tag, out_sum);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("sum[tag%0d]", e.tag), 64'(out_sum), 64'(e.sum));
          chk($sformatf("cout[tag%0d]", e.tag), 64'(out_cout), 64'(e.cout));
          chk($sformatf("ovf[tag%0d]", e.tag), 64'(out_ovf), 64'(e.ovf));
          chk($sformatf("zero[tag%0d]", e.tag), 64'(out_zero), 64'(e.zero));
          chk("tag_order", 64'(out_tag), 64'(e.tag));
          if (e.lat) chk($sformatf("latency[tag%0d]", e.tag), 64'(cyc - e.acc), 64'(STAGES));
        end
      end
      stalled_prev = out_valid && !out_ready;
      p_sum  = out_sum;
      p_tag  = out_tag;
      p_cout = out_cout;
      p_ovf  = out_ovf;
      p_zero = out_zero;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Present one operation and hold it until accepted; called at posedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic cin, input logic [4:0] tag, input sb_t exp_e);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    in_tag   = tag;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clock);
      if (in_ready) begin
        exp_e.acc = cyc;
        sbq.push_back(exp_e);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %0d never accepted", tag);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'(0));
  endtask

  vec_t vt[9];
  sb_t  ex;

  initial begin
    vt[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[5] = '{32'h000000FF, 32'h00000000, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'h000000FF, 32'h00000000, 1'b1, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0};
    vt[7] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[8] = '{32'h00FF00FF, 32'h0001FF01, 1'b0, 1'b0, 32'h01010000, 1'b0, 1'b0, 1'b0};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(out_sum), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    chk("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'(0));
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single operations from the table, each drained with latency checked.
    for (int i = 0; i < 9; i++) begin
      ex = '{vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero, 5'(i + 16), 0, 1'b1};
      send(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, 5'(i + 16), ex);
      in_valid = 1'b0;
      drain();
    end

    // Back-to-back stream with a three-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] ra, rb;
          logic        rc;
          ra = $urandom;
          rb = $urandom;
          rc = 1'($urandom_range(0, 1));
          send(ra, rb, 1'(i & 1), rc, 5'(i), model(ra, rb, 1'(i & 1), rc, 5'(i), 1'b0));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight and the output slot stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'(i + 1), 32'h10, 1'b0, 1'b0, 5'(i + 8), model(32'(i + 1), 32'h10, 1'b0, 1'b0, 5'(i + 8), 1'b0));
    end
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clock);
        #1;
        n++;
      end
    end
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'(0));
    chk("async_reset_sum", 64'(out_sum), 64'(0));
    sbq.delete();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("post_reset_quiet", 64'(out_valid), 64'(0));

    ex = model(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1, 5'd30, 1'b1);
    send(32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b1, 5'd30, ex);
    in_valid = 1'b0;
    drain();

    // Outputs hold the last result once the pipe has emptied.
    repeat (3) @(posedge clock);
    #1;
    chk("idle_hold_sum", 64'(out_sum), 64'(32'h22222222));
    chk("idle_hold_tag", 64'(out_tag), 64'(30));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
